// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] IFQ_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifq_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Instruction memory req/gnt/rvalid bus. master = fetch unit, slave = memory.
interface ifetch_queue_if;
  import ifq_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/ifq_fifo.sv
// In-order FIFO of {pc, instr} entries with synchronous flush.
// Head outputs read as zero while the FIFO is empty.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  ifq_entry_t       push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output ifq_entry_t       head
);

  ifq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Entry storage; no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: sequential PC generation, one outstanding
// imem request, in-order {pc, instr} buffering and flush-and-redirect.
// Optional macro IFQ_BYPASS_EN: a response arriving into an empty queue is
// presented to decode combinationally in the same cycle.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  ifetch_queue_if.master     imem,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pcplus4,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  ifq_state_t        state;
  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] fpc_issued;
  logic [CNT_W-1:0]  count;
  logic              fifo_valid;
  ifq_entry_t        head;
  ifq_entry_t        push_data;
  logic              has_credit;
  logic              issue;
  logic              rsp;
  logic              push;
  logic              pop;

  // Credit uses the registered count only; a same-cycle pop is not credited.
  assign has_credit     = (count < CNT_W'(DEPTH));
  assign imem.imem_req  = (state == REQ) && has_credit && !redirect && !reset;
  assign imem.imem_addr = fpc;
  assign issue          = imem.imem_req && imem.imem_gnt;
  assign rsp            = (state == WAIT) && imem.imem_rvalid && !redirect;
  assign pop            = fifo_valid && out_ready && !redirect;
  assign push_data      = '{pc: fpc_issued, instr: imem.imem_rdata};

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass    = rsp && (count == '0);
  // A bypassed beat consumed by decode never enters the FIFO.
  assign push      = rsp && !(bypass && out_ready);
  assign out_valid = fifo_valid || bypass;
  assign out_pc    = bypass ? fpc_issued : head.pc;
  assign out_instr = bypass ? imem.imem_rdata : head.instr;
`else
  assign push      = rsp;
  assign out_valid = fifo_valid;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
`endif

  assign out_pcplus4 = out_pc + 32'd4;

  // Fetch FSM: issue, wait for the response, or drop a response killed by redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= REQ;
      fpc        <= RESET_PC;
      fpc_issued <= RESET_PC;
    end else if (redirect) begin
      fpc <= redirect_pc;
      if (state != REQ) begin
        state <= imem.imem_rvalid ? REQ : DROP;
      end
    end else begin
      case (state)
        REQ: begin
          if (issue) begin
            fpc        <= fpc + 32'd4;
            fpc_issued <= fpc;
            state      <= WAIT;
          end
        end
        WAIT, DROP: begin
          if (imem.imem_rvalid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head_valid (fifo_valid),
    .head       (head)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue with a variable-latency memory model
// and a scoreboard of expected {pc, instr} beats.
module tb_ifetch_queue;
  import ifq_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic [31:0] out_instr;
  logic        out_ready;

  ifetch_queue_if imem ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_pcplus4 (out_pcplus4),
    .out_instr   (out_instr),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ifq_entry_t sb[$];

  // staged inputs, applied at the next falling edge
  logic        s_reset, s_redirect, s_ready, s_ready_rand, s_gnt_rand, s_bad_data;
  logic [31:0] s_rpc;
  int unsigned s_dly_lo, s_dly_hi;

  // memory model and order tracking
  logic        busy, killed, rv_now;
  int unsigned rsp_cnt;
  logic [31:0] txn_addr, next_fetch, last_pc;
  int unsigned n_pops;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit later, update model.
  task automatic tick();
    int unsigned qs0;
    ifq_entry_t  e;
    logic        fire;
    @(negedge clk);
    reset         = s_reset;
    redirect      = s_redirect;
    redirect_pc   = s_rpc;
    out_ready     = s_ready_rand ? 1'($urandom_range(0, 1)) : s_ready;
    imem.imem_gnt = s_gnt_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
    rv_now        = busy && (rsp_cnt == 0);
    imem.imem_rvalid = rv_now;
    imem.imem_rdata  = rv_now ? (s_bad_data ? 32'hDEAD_BEEF : mem_word(txn_addr)) : 32'h0;
    #1;
    if (!reset) begin
      qs0 = sb.size();
      if (imem.imem_req) begin
        check_b("req_while_outstanding", busy, 1'b0);
        check_b("req_without_credit", qs0 < DEPTH, 1'b1);
      end
      if (rv_now && !killed && !redirect) begin
        sb.push_back('{pc: txn_addr, instr: imem.imem_rdata});
        check_b("occupancy_le_depth", sb.size() <= DEPTH, 1'b1);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check_b("spurious_out_valid", out_valid, 1'b0);
        end else begin
          e = sb[0];
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.instr);
          check("out_pcplus4", out_pcplus4, e.pc + 32'd4);
          if (out_ready && !redirect) begin
            check("pc_order", e.pc, last_pc + 32'd4);
            last_pc = e.pc;
            n_pops++;
            void'(sb.pop_front());
          end
        end
      end
      fire = imem.imem_req && imem.imem_gnt;
      if (fire) begin
        check("imem_addr_at_grant", imem.imem_addr, next_fetch);
        busy       = 1'b1;
        killed     = 1'b0;
        txn_addr   = imem.imem_addr;
        rsp_cnt    = $urandom_range(s_dly_lo, s_dly_hi) - 1;
        next_fetch = next_fetch + 32'd4;
      end else if (rv_now) begin
        busy = 1'b0;
      end else if (busy) begin
        rsp_cnt--;
      end
      if (redirect) begin
        sb.delete();
        killed     = 1'b1;
        next_fetch = redirect_pc;
        last_pc    = redirect_pc - 32'd4;
      end
    end else begin
      sb.delete();
      busy       = 1'b0;
      killed     = 1'b0;
      next_fetch = 32'h0;
      last_pc    = 32'hFFFF_FFFC;
    end
  endtask

  initial begin
    int unsigned base;
    int unsigned guard;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    s_reset = 1'b1; s_redirect = 1'b0; s_rpc = '0; s_ready = 1'b0;
    s_ready_rand = 1'b0; s_gnt_rand = 1'b0; s_bad_data = 1'b0;
    s_dly_lo = 1; s_dly_hi = 1;
    busy = 1'b0; killed = 1'b0; rv_now = 1'b0; rsp_cnt = 0;
    txn_addr = '0; next_fetch = '0; last_pc = 32'hFFFF_FFFC; n_pops = 0;

    // reset state
    tick(); tick();
    check_b("reset_out_valid", out_valid, 1'b0);
    check_b("reset_imem_req", imem.imem_req, 1'b0);
    check("reset_out_pc", out_pc, 32'h0);
    check("reset_out_instr", out_instr, 32'h0);
    check("reset_imem_addr", imem.imem_addr, 32'h0);

    // fill with decode stalled
    s_reset = 1'b0;
    tick();
    check_b("first_req", imem.imem_req, 1'b1);
    check("first_out_pc", out_pc, 32'h0);
    repeat (15) tick();
    check("fill_entries", sb.size(), 32'd4);
    check_b("fill_req_stopped", imem.imem_req, 1'b0);
    check_b("fill_out_valid", out_valid, 1'b1);
    check("fill_head_pc", out_pc, 32'h0);
    check("fill_head_instr", out_instr, mem_word(32'h0));

    // drain
    s_ready = 1'b1;
    base = n_pops;
    repeat (20) tick();
    check_b("drain_progress", (n_pops - base) >= 8, 1'b1);

    // redirect while a request is outstanding; its response must be dropped
    s_dly_lo = 4; s_dly_hi = 4;
    guard = 0;
    do begin tick(); guard++; end while (!(busy && rsp_cnt == 3) && guard < 30);
    check_b("redir_found_grant", busy && rsp_cnt == 3, 1'b1);
    s_redirect = 1'b1; s_rpc = 32'h40; s_bad_data = 1'b1;
    tick();
    s_redirect = 1'b0;
    repeat (3) begin
      tick();
      check_b("redir_queue_empty", out_valid, 1'b0);
      check_b("redir_drop_no_req", imem.imem_req, 1'b0);
    end
    s_bad_data = 1'b0; s_dly_lo = 1; s_dly_hi = 1;
    guard = 0;
    do begin tick(); guard++; end while (!out_valid && guard < 10);
    check("redir_next_pc", out_pc, 32'h40);
    check("redir_next_instr", out_instr, mem_word(32'h40));

    // redirect coinciding with rvalid
    s_dly_lo = 2; s_dly_hi = 2;
    guard = 0;
    do begin tick(); guard++; end while (!(busy && rsp_cnt == 0) && guard < 30);
    check_b("sim_found_wait", busy && rsp_cnt == 0, 1'b1);
    s_redirect = 1'b1; s_rpc = 32'h40;
    tick();
    s_redirect = 1'b0;
    tick();
    check_b("sim_req", imem.imem_req, 1'b1);
    check("sim_addr", imem.imem_addr, 32'h40);
    check_b("sim_out_valid", out_valid, 1'b0);

    // fetch PC wrap at 2^32
    s_dly_lo = 1; s_dly_hi = 1;
    s_redirect = 1'b1; s_rpc = 32'hFFFF_FFF8;
    tick();
    s_redirect = 1'b0;
    base = n_pops;
    repeat (14) tick();
    check_b("wrap_progress", (n_pops - base) >= 4, 1'b1);

    // response into an empty queue with decode ready
    s_dly_lo = 3; s_dly_hi = 3;
    guard = 0;
    do begin tick(); guard++; end while (!(busy && rsp_cnt == 0 && sb.size() == 0) && guard < 40);
    check_b("byp_found_empty", busy && rsp_cnt == 0 && sb.size() == 0, 1'b1);
    tick();
`ifdef IFQ_BYPASS_EN
    check_b("bypass_same_cycle_valid", out_valid, 1'b1);
    check("bypass_same_cycle_instr", out_instr, mem_word(txn_addr));
`else
    check_b("no_bypass_same_cycle", out_valid, 1'b0);
`endif

    // reset with entries queued
    s_dly_lo = 1; s_dly_hi = 1; s_ready = 1'b0;
    s_redirect = 1'b1; s_rpc = 32'h200;
    tick();
    s_redirect = 1'b0;
    guard = 0;
    do begin tick(); guard++; end while (sb.size() != 3 && guard < 30);
    check("midreset_queued", sb.size(), 32'd3);
    s_reset = 1'b1;
    tick(); tick();
    check_b("midreset_out_valid", out_valid, 1'b0);
    check_b("midreset_req", imem.imem_req, 1'b0);
    check("midreset_addr", imem.imem_addr, 32'h0);
    s_reset = 1'b0;
    tick();
    check_b("midreset_req_after", imem.imem_req, 1'b1);
    check("midreset_addr_after", imem.imem_addr, 32'h0);

    // random latency, stalls and redirects
    s_gnt_rand = 1'b1; s_ready_rand = 1'b1; s_dly_lo = 1; s_dly_hi = 5;
    repeat (800) begin
      if ($urandom_range(0, 39) == 0) begin
        s_redirect = 1'b1;
        s_rpc = $urandom & 32'hFFFF_FFFC;
      end else begin
        s_redirect = 1'b0;
      end
      tick();
    end
    s_redirect = 1'b0; s_gnt_rand = 1'b0; s_ready_rand = 1'b0; s_ready = 1'b1;
    s_dly_lo = 1; s_dly_hi = 1;
    base = n_pops;
    repeat (20) tick();
    check_b("final_progress", (n_pops - base) >= 6, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front end for the 5-stage MIPS pipeline; sits directly upstream of the IF/ID register.
- Generates sequential fetch PCs and issues requests to a variable-latency instruction memory with a req/gnt/rvalid handshake.
- Buffers returned {pc, instr} pairs in a small in-order FIFO.
- Presents one instruction per cycle to the decode stage and supports flush-and-redirect on taken branch, jump or jr.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- redirect  in  1  flush the queue and restart fetch at redirect_pc; driven by the MEM-stage pcsrc/jump/link decision.
- redirect_pc  in  32  new fetch address; word aligned.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; equals the internal fetch PC.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; arrives at least 1 cycle after gnt; responses are in order.
- imem_rdata  in  32  fetched instruction.
- out_valid  out  1  head entry valid.
- out_pc  out  32  PC of the head entry.
- out_pcplus4  out  32  out_pc + 4, mod 2^32.
- out_instr  out  32  instruction of the head entry.
- out_ready  in  1  decode accepts the head entry; driven as ~stall from hazard detection.

Behaviour:
- Reset (synchronous; overrides everything):
  - fpc <= RESET_PC; count <= 0; state <= REQ.
  - Outputs the following cycle: out_valid=0, imem_req=0, out_pc/out_instr=0.
  - The instruction memory shares this reset, so no stale response arrives after reset.
- State machine, at most one request outstanding:
  - REQ: imem_req = (count < DEPTH) && !redirect. On imem_req && imem_gnt: fpc <= fpc+4 (wraps at 2^32), go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid: push {fpc_issued, imem_rdata}, go to REQ. fpc_issued is a register captured at grant.
  - DROP: imem_req=0. On imem_rvalid: discard the data, go to REQ.
- Pop: when out_valid && out_ready, the head advances. Push and pop in the same cycle leave count unchanged.
- Credit: a request is issued only if count < DEPTH, using registered count (a same-cycle pop is not credited). Because only one request is in flight, a push never finds the FIFO full.
- Redirect (highest priority after reset):
  - count <= 0, out_valid deasserts next cycle, fpc <= redirect_pc.
  - REQ -> REQ. The request is suppressed this cycle, so a grant is impossible.
  - WAIT without rvalid -> DROP.
  - WAIT with rvalid the same cycle -> REQ; the response is discarded.
  - DROP -> DROP, unless rvalid the same cycle, then -> REQ.
  - A same-cycle pop is ignored.
- Outputs come from the head register and are stable while out_valid && !out_ready.
- Entries are delivered in PC order with no duplicates or gaps between redirects.
- Pointers are log2(DEPTH) bits with natural wrap. count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when count==0, state==WAIT, imem_rvalid and !redirect, the response drives out_valid/out_pc/out_instr combinationally the same cycle.
  - If out_ready is also high, the entry is consumed and not pushed.
  - Otherwise it is pushed as normal.
- Undefined: a response is visible on out_valid no earlier than the cycle after imem_rvalid.

Decomposition:
- Shared package ifq_pkg holds:
  - the state enum {REQ, WAIT, DROP}, 2 bits;
  - localparam INSTR_W=32 and ADDR_W=32;
  - the default RESET_PC constant.
- One sub-module, ifq_fifo: a synchronous FIFO of {pc, instr} with push, pop, flush, count, head outputs, and the same clk/reset.
- The FSM, credit check and bypass logic stay in ifetch_queue.

Test Plan:
- Fill: reset, then gnt every REQ cycle, rvalid 1 cycle after gnt, out_ready=0 → exactly 4 entries, PCs 0x0, 0x4, 0x8, 0xC. imem_req stays 0 with count=4.
- Drain: from full, set out_ready=1 → out_pc sequence 0x0, 0x4, 0x8, 0xC, then 0x10 ..., out_pcplus4 = out_pc+4 each beat, no gaps.
- Redirect mid-flight: redirect=1, redirect_pc=0x40 while in WAIT, rvalid 3 cycles later with data 0xDEADBEEF → that data is never output. The next out_pc is 0x40 and the queue was empty in between.
- Simultaneous redirect and rvalid in WAIT → response dropped, state REQ next cycle, imem_addr=0x40.
- Variable latency plus stall: random gnt/rvalid delays of 1–5 cycles, out_ready toggling → in-order PC stream checked against a reference model, count never exceeds 4.
- Reset mid-operation: assert reset with 3 entries queued → next cycle out_valid=0, imem_addr=RESET_PC. With IFQ_BYPASS_EN, on an empty queue with out_ready=1, the instruction appears on out_instr the same cycle as rvalid.
